// File: rtl/p2s_arb_pkg.sv
// Shared types and defaults for the parallel-to-serial request arbiter.
// Holds the FSM state encoding and the timing defaults used by p2s_arbiter.
package p2s_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } p2s_state_e;

  localparam int P2S_SYNC_CYCLES_DEF = 2;
  localparam int P2S_XFER_MARGIN     = 8;

endpackage

// File: rtl/p2s_rr_pick.sv
// Combinational round-robin winner search, starting at last_grant+1 and wrapping.
// Ports: req (requests), last_grant (previous winner) -> winner (index), valid.
module p2s_rr_pick
  import p2s_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  int unsigned idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_w = IW'(idx);
      if (!valid && req[idx_w]) begin
        valid  = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/p2s_arbiter.sv
// Arbitrates NUM_REQ requesters onto one serializer: grant, sync strobe, wait, gap.
// Ports: clk, rst_n, req, req_data in; ack, done, busy, p2s_sync, p2s_data out.
// Define P2S_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module p2s_arbiter
  import p2s_arb_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int NUM_REQ     = 4,
  parameter int SYNC_CYCLES = P2S_SYNC_CYCLES_DEF,
  parameter int XFER_CYCLES = DATA_BITS + P2S_XFER_MARGIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic                         p2s_sync,
  output logic [DATA_BITS-1:0]         p2s_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(XFER_CYCLES + 1);
  localparam int SW = $clog2(SYNC_CYCLES + 1);

  p2s_state_e           state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 sync_q, sync_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [IW-1:0]        pick_last;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [DATA_BITS-1:0] words [NUM_REQ];

`ifdef P2S_ARB_FIXED_PRIO_EN
  // Search always starts at index 0, which is plain lowest-index priority.
  assign pick_last = IW'(NUM_REQ - 1);
`else
  logic [IW-1:0] last_q, last_d;
  assign pick_last = last_q;
`endif

  p2s_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req),
    .last_grant (pick_last),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    sync_d  = sync_q;
    ack_d   = '0;
    done_d  = '0;
    busy_d  = busy_q;
    scnt_d  = scnt_q;
    cnt_d   = cnt_q;
`ifndef P2S_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d          = SYNC;
          grant_d          = pick_idx;
          data_d           = words[pick_idx];
          ack_d[pick_idx]  = 1'b1;
          sync_d           = 1'b1;
          busy_d           = 1'b1;
          scnt_d           = SW'(SYNC_CYCLES - 1);
`ifndef P2S_ARB_FIXED_PRIO_EN
          last_d           = pick_idx;
`endif
        end
      end
      SYNC: begin
        if (scnt_q == '0) begin
          state_d = WAIT;
          sync_d  = 1'b0;
          cnt_d   = CW'(XFER_CYCLES);
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      WAIT: begin
        // done fires on the edge the counter reaches zero
        if (cnt_q <= CW'(1)) begin
          cnt_d           = '0;
          done_d[grant_q] = 1'b1;
          state_d         = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sync_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      data_q  <= '0;
      sync_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      scnt_q  <= '0;
      cnt_q   <= '0;
`ifndef P2S_ARB_FIXED_PRIO_EN
      last_q  <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
`ifndef P2S_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign p2s_sync = sync_q;
  assign p2s_data = data_q;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Scoreboard bench for p2s_arbiter: directed requests, queued expected acks/dones.
// A negedge monitor pops and checks every ack/done plus strobe timing.
module tb_p2s_arbiter;

  localparam int DB = 16;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0] ack;
  logic [NR-1:0] done;
  logic          busy;
  logic          p2s_sync;
  logic [DB-1:0] p2s_data;

  p2s_arbiter #(
    .DATA_BITS   (DB),
    .NUM_REQ     (NR),
    .SYNC_CYCLES (2),
    .XFER_CYCLES (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .busy     (busy),
    .p2s_sync (p2s_sync),
    .p2s_data (p2s_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    int            idx;
    logic [DB-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int last_ack_cyc  = 0;
  int last_done_cyc = 0;

  logic [DB-1:0] w [NR];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input int i);
    exp_t e;
    e.is_done = d;
    e.idx     = i;
    e.data    = w[i];
    exp_q.push_back(e);
  endtask

  task automatic push_xfer(input int i);
    push(1'b0, i);
    push(1'b1, i);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic prev_sync = 1'b0;
  bit   have_fall = 1'b0;
  bit   chk_busy  = 1'b0;
  int   rise_cyc  = 0;
  int   fall_cyc  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_sync = 1'b0;
      have_fall = 1'b0;
      chk_busy  = 1'b0;
    end else begin
      if (chk_busy) begin
        chk("busy_after_done", busy, 0);
        chk_busy = 1'b0;
      end
      if (p2s_sync && !prev_sync) begin
        if (have_fall) chk("sync_gap_ge2", (cyc - fall_cyc) >= 2, 1);
        rise_cyc = cyc;
      end
      if (!p2s_sync && prev_sync) begin
        chk("sync_len", cyc - rise_cyc, 2);
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      prev_sync = p2s_sync;
      if (ack !== '0) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        chk("ack_onehot", $onehot(ack), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", ack, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_kind", e.is_done, 0);
          chk("ack_idx", ack, 1 << e.idx);
          chk("ack_data", p2s_data, e.data);
        end
      end
      if (done !== '0) begin
        last_done_cyc = cyc;
        chk("done_onehot", $onehot(done), 1);
        chk("done_latency", cyc - rise_cyc, 26);
        chk("busy_at_done", busy, 1);
        chk_busy = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", e.is_done, 1);
          chk("done_idx", done, 1 << e.idx);
          chk("data_stable", p2s_data, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int g = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < 400) begin
      tick(1);
      g++;
    end
    chk("quiet_timeout", g >= 400, 0);
    tick(1);
  endtask

  task automatic wait_acks(input int target);
    int g = 0;
    while (ack_cnt < target && g < 400) begin
      tick(1);
      g++;
    end
    chk("ack_timeout", ack_cnt >= target, 1);
  endtask

  task automatic reset_dut();
    req   = '0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    w[0] = 16'h1234;
    w[1] = 16'hBEEF;
    w[2] = 16'hA5C3;
    w[3] = 16'h0F0F;
    req_data = {w[3], w[2], w[1], w[0]};
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync", p2s_sync, 0);
    chk("rst_data", p2s_data, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single request from requester 2
    req = 4'b0100;
    push_xfer(2);
    tick(1);
    req = '0;
    wait_quiet();

`ifdef P2S_ARB_FIXED_PRIO_EN
    // Fixed priority: 1 always beats 3
    reset_dut();
    base = ack_cnt;
    for (int k = 0; k < 3; k++) push_xfer(1);
    req = 4'b1010;
    wait_acks(base + 3);
    req = '0;
    wait_quiet();
`else
    // Fairness with all requests held
    reset_dut();
    base = ack_cnt;
    push_xfer(0);
    push_xfer(1);
    push_xfer(2);
    push_xfer(3);
    push_xfer(0);
    push_xfer(1);
    req = 4'b1111;
    wait_acks(base + 6);
    req = '0;
    wait_quiet();
`endif

    // Reset in the middle of WAIT; requester 1 never completes
    reset_dut();
    push(1'b0, 1);
    req = 4'b0010;
    tick(1);
    req = '0;
    tick(11);
    rst_n = 1'b0;
    #1;
    chk("midrst_sync", p2s_sync, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", p2s_data, 0);
    tick(2);
    push_xfer(0);
    rst_n = 1'b1;
    req   = 4'b1001;
    tick(1);
    req = '0;
    wait_quiet();

    // Request raised during WAIT is served right after GAP
    base = ack_cnt;
    push_xfer(0);
    push_xfer(1);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(8);
    req = 4'b0010;
    wait_acks(base + 2);
    req = '0;
    chk("pending_ack_delay", last_ack_cyc - last_done_cyc, 2);
    wait_quiet();

    // One-cycle pulse on req[3] during WAIT is dropped
    push_xfer(0);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(8);
    req = 4'b1000;
    tick(1);
    req = '0;
    wait_quiet();
    tick(30);

    chk("exp_q_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/p2s_arbiter.md
P2S_ARBITER -- requirements
Module: p2s_arbiter

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16: width of one serializer word.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 SHALL have parameter SYNC_CYCLES, default 2: number of cycles p2s_sync is held high.
REQ-004 SHALL have parameter XFER_CYCLES, default DATA_BITS+8: serializer occupancy in cycles after sync drops.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req, input, NUM_REQ: level request per requester.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_BITS: word for requester i in bits [i*DATA_BITS +: DATA_BITS].
REQ-009 SHALL have port ack, output, NUM_REQ: one-cycle pulse when the word is latched.
REQ-010 SHALL have port done, output, NUM_REQ: one-cycle pulse when the transfer completes.
REQ-011 SHALL have port busy, output, 1: high whenever state != IDLE.
REQ-012 SHALL have port p2s_sync, output, 1: start strobe to the serializer.
REQ-013 SHALL have port p2s_data, output, DATA_BITS: word presented to the serializer.

Function
REQ-014 SHALL implement the states IDLE -> SYNC -> WAIT -> GAP -> IDLE with no other transitions.
REQ-015 In IDLE with req != 0, SHALL on one edge latch the winner index, copy its word to p2s_data, pulse ack[winner], and enter SYNC.
REQ-016 SHALL arbitrate round-robin: search starts at last_grant+1 mod NUM_REQ and wraps.
REQ-017 SYNC SHALL drive p2s_sync high for exactly SYNC_CYCLES cycles, then enter WAIT with p2s_sync low.
REQ-018 WAIT SHALL load a down-counter of width $clog2(XFER_CYCLES+1) with XFER_CYCLES; at zero it SHALL pulse done[grant] and enter GAP.
REQ-019 GAP SHALL last one cycle with p2s_sync low, guaranteeing the serializer's edge detector samples 0 before the next start.
REQ-020 p2s_data SHALL remain stable from the ack edge through the done pulse.
REQ-021 Requests raised during SYNC, WAIT or GAP SHALL be held pending and arbitrated in the next IDLE cycle.
REQ-022 A request deasserted before it is arbitrated SHALL be ignored and not remembered.
REQ-023 A requester still asserting req after its done SHALL be treated as a new request and arbitrated normally.
REQ-024 At most one bit of ack and at most one bit of done SHALL be high in any cycle.

Reset
REQ-025 Assertion of rst_n=0 SHALL, asynchronously and in any state (including mid-transfer), force:
- state = IDLE
- p2s_sync = 0, p2s_data = 0
- ack = 0, done = 0, busy = 0
- counter = 0
- last_grant = NUM_REQ-1, so requester 0 wins first after reset.
REQ-026 A transfer interrupted by reset SHALL NOT produce done.

Configuration
REQ-027 With macro P2S_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant SHALL be unused.
REQ-028 Without P2S_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-016.

Structure
REQ-029 Package p2s_arb_pkg SHALL hold:
- the state enum (IDLE, SYNC, WAIT, GAP)
- defaults for SYNC_CYCLES and the XFER_CYCLES margin (8).
REQ-030 The winner search SHALL be the combinational sub-module p2s_rr_pick (inputs req and last_grant; outputs winner index and valid), instantiated once.

Verification (DATA_BITS=16, NUM_REQ=4, SYNC_CYCLES=2, XFER_CYCLES=24)
REQ-031 Single request: req[2]=1 with word 0xA5C3 -> ack[2] on the next edge, p2s_data=0xA5C3, p2s_sync high exactly 2 cycles, done[2] 26 cycles after sync rises, busy low 1 cycle later.
REQ-032 Fairness: req=4'b1111 held -> grant order 0,1,2,3,0,1, each with exactly one ack and one done.
REQ-033 Fixed priority: P2S_ARB_FIXED_PRIO_EN defined, req=4'b1010 held -> every grant goes to requester 1.
REQ-034 Reset mid-transfer: rst_n low at cycle 10 of WAIT -> p2s_sync, busy, ack and done low immediately; no done; after release with req=4'b1001, requester 0 wins.
REQ-035 Pending request: req[1] raised during requester 0's WAIT -> ack[1] in the first IDLE cycle after GAP; p2s_sync low for 2 or more cycles between the two strobes.
REQ-036 Dropped request: req[3] high for 1 cycle during WAIT only -> no ack[3] and no done[3].
